// File: rtl/xc20xx_dffsr_dlatch.sv
// XC20XX CLB storage bit: positive-edge D flip-flop with async set/reset, or transparent-high D latch.
// Define XC20XX_DLATCH_SR_EN to make latch mode honour S and R as well.
`timescale 1ns/1ps

module xc20xx_dffsr_dlatch #(
   parameter string MODE        = "DFF",
   parameter logic  INIT        = 1'b0,
   parameter string SR_PRIORITY = "RESET"
) (
   input  logic D,
   input  logic S,
   input  logic R,
   input  logic C,
   output logic Q
);

   localparam logic SET_WINS = (SR_PRIORITY == "SET");

`ifdef XC20XX_DLATCH_SR_EN
   localparam bit LATCH_SR = 1'b1;
`else
   localparam bit LATCH_SR = 1'b0;
`endif

   if (MODE != "DFF" && MODE != "DLATCH") begin : g_bad_mode
      $fatal(1, "xc20xx_dffsr_dlatch: illegal MODE '%s' (expected DFF or DLATCH)", MODE);
   end
   if (SR_PRIORITY != "RESET" && SR_PRIORITY != "SET") begin : g_bad_prio
      $fatal(1, "xc20xx_dffsr_dlatch: illegal SR_PRIORITY '%s' (expected RESET or SET)", SR_PRIORITY);
   end

   logic sr_act;   // set or reset currently asserted
   logic sr_val;   // value forced while sr_act
   logic sr_hold;  // last forced value, held after release

   assign sr_act = R | S;
   assign sr_val = (S && R) ? SET_WINS : S;

   // NOTE: always_latch states the latch is intended, so it is not mistaken for a missing else.
   always_latch begin
      if (R || S) sr_hold <= (S && R) ? SET_WINS : S;
   end

   if (MODE == "DFF") begin : g_dff
      logic q_r      = INIT;
      logic forced_r = 1'b0;

      // NOTE: non-blocking assignment samples the pre-edge D, giving one-edge latency without races.
      always_ff @(posedge C) begin
         q_r <= D;
      end

      // Remembers that set/reset fired since the last clock edge; the edge hands control back to q_r.
      always_ff @(posedge C or posedge sr_act) begin
         if (sr_act) forced_r <= 1'b1;
         else        forced_r <= 1'b0;
      end

      assign Q = sr_act ? sr_val : (forced_r ? sr_hold : q_r);
   end else begin : g_dlatch
      logic q_l = INIT;

      always_latch begin
         if (C) q_l <= D;
      end

      if (LATCH_SR) begin : g_sr
         logic forced_l = 1'b0;

         // Forced value persists after release until the gate opens again.
         always_latch begin
            if (sr_act) forced_l <= 1'b1;
            else if (C) forced_l <= 1'b0;
         end

         assign Q = sr_act ? sr_val : (forced_l ? sr_hold : q_l);
      end else begin : g_no_sr
         logic unused_sr;
         assign unused_sr = sr_act ^ sr_val ^ sr_hold;
         assign Q = q_l;
      end
   end

endmodule

// File: tb/tb_xc20xx_dffsr_dlatch.sv
// Self-checking bench for xc20xx_dffsr_dlatch: directed test-plan steps plus random stimulus
// compared every step against a rule-level model of three configurations.
`timescale 1ns/1ps

module tb_xc20xx_dffsr_dlatch;

   logic D, S, R, C;
   logic q_dff, q_dset, q_lat;

   xc20xx_dffsr_dlatch #(.MODE("DFF"), .INIT(1'b0), .SR_PRIORITY("RESET")) u_dff (
      .D(D), .S(S), .R(R), .C(C), .Q(q_dff)
   );
   xc20xx_dffsr_dlatch #(.MODE("DFF"), .INIT(1'b1), .SR_PRIORITY("SET")) u_dset (
      .D(D), .S(S), .R(R), .C(C), .Q(q_dset)
   );
   xc20xx_dffsr_dlatch #(.MODE("DLATCH"), .INIT(1'b0), .SR_PRIORITY("RESET")) u_lat (
      .D(D), .S(S), .R(R), .C(C), .Q(q_lat)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   logic m_dff, m_dset, m_lat;
   event chk_ev;

`ifdef XC20XX_DLATCH_SR_EN
   localparam bit LATCH_SR = 1'b1;
`else
   localparam bit LATCH_SR = 1'b0;
`endif

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Stored value per configuration, derived straight from the behavioural rules.
   task automatic model_update(input bit rise);
      if (R || S) begin
         m_dff  = R ? 1'b0 : 1'b1;
         m_dset = S ? 1'b1 : 1'b0;
      end else if (rise) begin
         m_dff  = D;
         m_dset = D;
      end
      if (LATCH_SR && (R || S)) m_lat = R ? 1'b0 : 1'b1;
      else if (C)               m_lat = D;
   endtask

   task automatic settle();
      #1;
      -> chk_ev;
      #1;
   endtask

   task automatic clk_rise();
      C = 1'b1; model_update(1'b1); settle();
   endtask

   task automatic clk_fall();
      C = 1'b0; model_update(1'b0); settle();
   endtask

   task automatic set_d(input logic v);
      D = v; model_update(1'b0); settle();
   endtask

   task automatic set_sr(input logic s, input logic r);
      S = s; R = r; model_update(1'b0); settle();
   endtask

   initial begin
      forever begin
         @(chk_ev);
         check("model_dff",  q_dff,  m_dff);
         check("model_dset", q_dset, m_dset);
         check("model_lat",  q_lat,  m_lat);
      end
   end

   initial begin
      D = 1'b0; S = 1'b0; R = 1'b0; C = 1'b0;
      m_dff = 1'b0; m_dset = 1'b1; m_lat = 1'b0;
      #1;
      check("powerup_dff_init0", q_dff,  1'b0);
      check("powerup_dff_init1", q_dset, 1'b1);
      check("powerup_lat_init0", q_lat,  1'b0);
      #1;

      // Flip-flop capture
      set_d(1'b1);  check("dff_no_edge",      q_dff, 1'b0);
      clk_rise();   check("dff_capture_1",    q_dff, 1'b1);
      set_d(1'b0);  check("dff_hold_no_edge", q_dff, 1'b1);
      clk_fall();
      clk_rise();   check("dff_capture_0",    q_dff, 1'b0);
      clk_fall();

      // Asynchronous reset and set between edges
      set_d(1'b1);
      clk_rise();   check("dff_recapture_1",  q_dff, 1'b1);
      clk_fall();
      set_sr(1'b0, 1'b1); check("dff_r_async",        q_dff, 1'b0);
      set_sr(1'b0, 1'b0); check("dff_r_release_hold", q_dff, 1'b0);
      set_sr(1'b1, 1'b0); check("dff_s_async",        q_dff, 1'b1);
      set_sr(1'b0, 1'b0); check("dff_s_release_hold", q_dff, 1'b1);
      set_sr(1'b0, 1'b1);
      clk_rise();         check("dff_r_beats_clock",  q_dff, 1'b0);
      clk_fall();
      set_sr(1'b0, 1'b0); check("dff_release_no_capture", q_dff, 1'b0);

      // Simultaneous set and reset
      set_d(1'b0);
      clk_rise();         check("dset_capture_0",   q_dset, 1'b0);
      clk_fall();
      set_d(1'b1);
      set_sr(1'b1, 1'b1); check("sr_both_reset_pri", q_dff,  1'b0);
                          check("sr_both_set_pri",   q_dset, 1'b1);
      set_sr(1'b0, 1'b0); check("sr_release_dset",   q_dset, 1'b1);
      clk_rise();         check("sr_after_edge_dff",  q_dff,  1'b1);
                          check("sr_after_edge_dset", q_dset, 1'b1);
      clk_fall();

      // Latch transparency and capture on the falling gate
      clk_rise();
      set_d(1'b0);  check("lat_track_0",   q_lat, 1'b0);
      set_d(1'b1);  check("lat_track_1",   q_lat, 1'b1);
      set_d(1'b0);  check("lat_track_0b",  q_lat, 1'b0);
      set_d(1'b1);
      clk_fall();   check("lat_capture_1", q_lat, 1'b1);
      set_d(1'b0);  check("lat_hold_d0",   q_lat, 1'b1);
      set_d(1'b1);
      set_d(1'b0);  check("lat_hold_d0b",  q_lat, 1'b1);

      // Latch with gate closed and reset pulsed
      set_sr(1'b0, 1'b1); check("lat_reset_gate_low", q_lat, LATCH_SR ? 1'b0 : 1'b1);
      set_sr(1'b0, 1'b0); check("lat_reset_release",  q_lat, LATCH_SR ? 1'b0 : 1'b1);

      // Random stimulus against the model
      for (int i = 0; i < 3000; i++) begin
         int unsigned pick;
         pick = $urandom_range(0, 9);
         if (pick < 4) begin
            if (C) clk_fall();
            else   clk_rise();
         end else if (pick < 7) begin
            set_d(1'($urandom_range(0, 1)));
         end else begin
            set_sr($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
